onchip_ram_2p_arb: RTL and testbench

- Parametrised on-chip RAM with two Avalon-MM slave ports, s1 and s2, sharing one memory array.
- Adds several features over the previous single-port RAM: configurable data width and depth, selectable read latency (1 or 2), readdatavalid/waitrequest handshakes, round-robin arbitration between ports, and out-of-range address protection.
- Sits on the Nios II system interconnect as general program/data memory.
- Lets the CPU and a second master (DMA or peripheral) share one RAM.

---
 rtl/onchip_ram_2p_arb.sv | 172 +++++++++++++++++
 tb/tb_onchip_ram_2p_arb.sv | 375 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/onchip_ram_2p_arb.sv
// Two-port (s1/s2) Avalon-MM on-chip RAM sharing a single array.
// One access is accepted per cycle under round-robin arbitration; reads
// return after 1 or 2 cycles on the port that issued them.
module onchip_ram_2p_arb #(
  parameter int    DATA_WIDTH   = 32,
  parameter int    DEPTH        = 2048,
  parameter int    ADDR_WIDTH   = 11,
  parameter int    READ_LATENCY = 1,
  parameter string INIT_FILE    = ""
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    clken,
  input  logic                    reset_req,
  input  logic                    freeze,
  input  logic [ADDR_WIDTH-1:0]   s1_address,
  input  logic                    s1_chipselect,
  input  logic                    s1_read,
  input  logic                    s1_write,
  input  logic [DATA_WIDTH/8-1:0] s1_byteenable,
  input  logic [DATA_WIDTH-1:0]   s1_writedata,
  output logic [DATA_WIDTH-1:0]   s1_readdata,
  output logic                    s1_readdatavalid,
  output logic                    s1_waitrequest,
  input  logic [ADDR_WIDTH-1:0]   s2_address,
  input  logic                    s2_chipselect,
  input  logic                    s2_read,
  input  logic                    s2_write,
  input  logic [DATA_WIDTH/8-1:0] s2_byteenable,
  input  logic [DATA_WIDTH-1:0]   s2_writedata,
  output logic [DATA_WIDTH-1:0]   s2_readdata,
  output logic                    s2_readdatavalid,
  output logic                    s2_waitrequest
);

  localparam int BE_W  = DATA_WIDTH / 8;
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic req1, req2, en, gnt1, gnt2;
  // last_q = 1 means s2 was granted most recently, so s1 wins the next tie.
  logic last_q, last_d;

  // Request decode and round-robin grant; grants are computed even when
  // stalled so waitrequest stays a pure function of request and enable.
  always_comb begin
    req1 = s1_chipselect & (s1_read | s1_write);
    req2 = s2_chipselect & (s2_read | s2_write);
    en   = clken & ~reset_req & ~freeze;
    gnt1 = req1 & (~req2 | last_q);
    gnt2 = req2 & (~req1 | ~last_q);
  end

  assign s1_waitrequest = req1 & ~(gnt1 & en);
  assign s2_waitrequest = req2 & ~(gnt2 & en);

  // ---- stage p0: accept, port mux, array access ----
  logic                  acc_p0, port_p0, wr_p0, rd_p0, inrange_p0;
  logic                  wen_p0, vld_p0;
  logic [ADDR_WIDTH-1:0] addr_p0;
  logic [IDX_W-1:0]      idx_p0;
  logic [BE_W-1:0]       be_p0;
  logic [DATA_WIDTH-1:0] wdata_p0, rdata_p0;

  // Select the granted port's command; read+write together acts as a write,
  // and out-of-range addresses read as zero and never write.
  always_comb begin
    acc_p0     = en & (gnt1 | gnt2);
    port_p0    = gnt2;
    addr_p0    = port_p0 ? s2_address    : s1_address;
    wr_p0      = port_p0 ? s2_write      : s1_write;
    rd_p0      = port_p0 ? s2_read       : s1_read;
    be_p0      = port_p0 ? s2_byteenable : s1_byteenable;
    wdata_p0   = port_p0 ? s2_writedata  : s1_writedata;
    idx_p0     = addr_p0[IDX_W-1:0];
    inrange_p0 = ({1'b0, addr_p0} < (ADDR_WIDTH + 1)'(DEPTH));
    wen_p0     = acc_p0 & wr_p0 & inrange_p0;
    vld_p0     = acc_p0 & rd_p0 & ~wr_p0;
    rdata_p0   = inrange_p0 ? mem[idx_p0] : '0;
    last_d     = acc_p0 ? port_p0 : last_q;
  end

  // Byte-lane write into the shared array; contents are never reset.
  always_ff @(posedge clk) begin
    if (wen_p0) begin
      for (int i = 0; i < BE_W; i++) begin
        if (be_p0[i]) mem[idx_p0][i*8 +: 8] <= wdata_p0[i*8 +: 8];
      end
    end
  end

  // Last-grant register; reset favours s1 on the first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) last_q <= 1'b1;
    else       last_q <= last_d;
  end

  // Source feeding the per-port output registers.
  logic                  out_vld, out_port;
  logic [DATA_WIDTH-1:0] out_data;

  if (READ_LATENCY == 2) begin : g_lat2
    // ---- stage p1: extra read register carrying the port tag ----
    logic                  vld_p1_q, vld_p1_d, port_p1_q, port_p1_d;
    logic [DATA_WIDTH-1:0] data_p1_q, data_p1_d;

    // Next-state for the tagged read register.
    always_comb begin
      vld_p1_d  = vld_p0;
      port_p1_d = port_p0;
      data_p1_d = vld_p0 ? rdata_p0 : data_p1_q;
    end

    // Valid/tag are control and cleared by reset; a read in flight is dropped.
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        vld_p1_q  <= 1'b0;
        port_p1_q <= 1'b0;
      end else begin
        vld_p1_q  <= vld_p1_d;
        port_p1_q <= port_p1_d;
      end
    end

    // Read data is only ever observed alongside vld_p1_q, so no reset.
    always_ff @(posedge clk) begin
      data_p1_q <= data_p1_d;
    end

    assign out_vld  = vld_p1_q;
    assign out_port = port_p1_q;
    assign out_data = data_p1_q;
  end else begin : g_lat1
    assign out_vld  = vld_p0;
    assign out_port = port_p0;
    assign out_data = rdata_p0;
  end

  // ---- output stage: per-port readdata/readdatavalid registers ----
  logic                  s1_rvld_q, s1_rvld_d, s2_rvld_q, s2_rvld_d;
  logic [DATA_WIDTH-1:0] s1_rdata_q, s1_rdata_d, s2_rdata_q, s2_rdata_d;

  // Route the returning read to its originating port; readdata holds otherwise.
  always_comb begin
    s1_rvld_d  = out_vld & ~out_port;
    s2_rvld_d  = out_vld &  out_port;
    s1_rdata_d = s1_rvld_d ? out_data : s1_rdata_q;
    s2_rdata_d = s2_rvld_d ? out_data : s2_rdata_q;
  end

  // Output registers; readdata is visible at the ports, so it clears on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_rvld_q  <= 1'b0;
      s2_rvld_q  <= 1'b0;
      s1_rdata_q <= '0;
      s2_rdata_q <= '0;
    end else begin
      s1_rvld_q  <= s1_rvld_d;
      s2_rvld_q  <= s2_rvld_d;
      s1_rdata_q <= s1_rdata_d;
      s2_rdata_q <= s2_rdata_d;
    end
  end

  assign s1_readdata      = s1_rdata_q;
  assign s2_readdata      = s2_rdata_q;
  assign s1_readdatavalid = s1_rvld_q;
  assign s2_readdatavalid = s2_rvld_q;

endmodule

// File: tb/tb_onchip_ram_2p_arb.sv
// Bench for onchip_ram_2p_arb: a latency-1 and a latency-2 instance share
// the same stimulus and are compared against a transaction-level model.
module tb_onchip_ram_2p_arb;
  localparam int DW    = 32;
  localparam int DEPTH = 1000;
  localparam int AW    = 10;
  localparam int BW    = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          clken = 1'b1, reset_req = 1'b0, freeze = 1'b0;
  logic [AW-1:0] s1_address = '0, s2_address = '0;
  logic          s1_chipselect = 1'b0, s1_read = 1'b0, s1_write = 1'b0;
  logic          s2_chipselect = 1'b0, s2_read = 1'b0, s2_write = 1'b0;
  logic [BW-1:0] s1_byteenable = '0, s2_byteenable = '0;
  logic [DW-1:0] s1_writedata = '0, s2_writedata = '0;
  logic [DW-1:0] a_rd1, a_rd2, b_rd1, b_rd2;
  logic          a_rv1, a_rv2, b_rv1, b_rv2, a_wr1, a_wr2, b_wr1, b_wr2;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  onchip_ram_2p_arb #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .READ_LATENCY(1)) u_l1 (
    .clk(clk), .reset(rst), .clken(clken), .reset_req(reset_req), .freeze(freeze),
    .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read), .s1_write(s1_write),
    .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata), .s1_readdata(a_rd1),
    .s1_readdatavalid(a_rv1), .s1_waitrequest(a_wr1),
    .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read), .s2_write(s2_write),
    .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata), .s2_readdata(a_rd2),
    .s2_readdatavalid(a_rv2), .s2_waitrequest(a_wr2));

  onchip_ram_2p_arb #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .READ_LATENCY(2)) u_l2 (
    .clk(clk), .reset(rst), .clken(clken), .reset_req(reset_req), .freeze(freeze),
    .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read), .s1_write(s1_write),
    .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata), .s1_readdata(b_rd1),
    .s1_readdatavalid(b_rv1), .s1_waitrequest(b_wr1),
    .s2_address(s2_address), .s2_chipselect(s2_chipselect), .s2_read(s2_read), .s2_write(s2_write),
    .s2_byteenable(s2_byteenable), .s2_writedata(s2_writedata), .s2_readdata(b_rd2),
    .s2_readdatavalid(b_rv2), .s2_waitrequest(b_wr2));

  // ---------------- reference model ----------------
  logic [DW-1:0] mm [DEPTH];
  bit            last2 = 1'b1;               // 1: s2 granted most recently
  bit            ev [4] = '{default: 1'b0};  // expected valid: L1 s1, L1 s2, L2 s1, L2 s2
  logic [DW-1:0] ed [4] = '{default: '0};    // expected (held) readdata
  bit            nv [2] = '{default: 1'b0};  // latency-2 results due after the next edge
  logic [DW-1:0] nd [2] = '{default: '0};

  function automatic int model_grant(bit r1, bit r2);
    if (r1 && r2) return last2 ? 1 : 2;
    if (r1) return 1;
    if (r2) return 2;
    return 0;
  endfunction

  bit nr1, nr2, nen, nw1, nw2;
  int ng;
  always @(negedge clk) begin
    #1;
    nr1 = s1_chipselect & (s1_read | s1_write);
    nr2 = s2_chipselect & (s2_read | s2_write);
    nen = clken & ~reset_req & ~freeze;
    ng  = model_grant(nr1, nr2);
    nw1 = nr1 & ~(nen & (ng == 1));
    nw2 = nr2 & ~(nen & (ng == 2));
    checks++;
    if (a_wr1 !== nw1) begin failures++; $display("FAIL waitreq_s1_l1 got=%b exp=%b t=%0t", a_wr1, nw1, $time); end
    checks++;
    if (a_wr2 !== nw2) begin failures++; $display("FAIL waitreq_s2_l1 got=%b exp=%b t=%0t", a_wr2, nw2, $time); end
    checks++;
    if (b_wr1 !== nw1) begin failures++; $display("FAIL waitreq_s1_l2 got=%b exp=%b t=%0t", b_wr1, nw1, $time); end
    checks++;
    if (b_wr2 !== nw2) begin failures++; $display("FAIL waitreq_s2_l2 got=%b exp=%b t=%0t", b_wr2, nw2, $time); end
  end

  bit            pr1, pr2, pen, pwr, prd;
  int            pg, pa;
  logic [BW-1:0] pbe;
  logic [DW-1:0] pwd, pd;
  logic          ov [4];
  logic [DW-1:0] od [4];
  always @(posedge clk or posedge rst) begin
    for (int k = 0; k < 4; k++) ev[k] = 1'b0;
    if (rst) begin
      for (int k = 0; k < 4; k++) ed[k] = '0;
      for (int p = 0; p < 2; p++) nv[p] = 1'b0;
      last2 = 1'b1;
    end else begin
      for (int p = 0; p < 2; p++) begin
        ev[2+p] = nv[p];
        if (nv[p]) ed[2+p] = nd[p];
        nv[p] = 1'b0;
      end
      pr1 = s1_chipselect & (s1_read | s1_write);
      pr2 = s2_chipselect & (s2_read | s2_write);
      pen = clken & ~reset_req & ~freeze;
      pg  = model_grant(pr1, pr2);
      if (pen && pg != 0) begin
        last2 = (pg == 2);
        pa  = (pg == 1) ? int'(s1_address) : int'(s2_address);
        pwr = (pg == 1) ? s1_write : s2_write;
        prd = (pg == 1) ? s1_read : s2_read;
        pbe = (pg == 1) ? s1_byteenable : s2_byteenable;
        pwd = (pg == 1) ? s1_writedata : s2_writedata;
        if (pwr) begin
          if (pa < DEPTH)
            for (int i = 0; i < BW; i++) if (pbe[i]) mm[pa][8*i +: 8] = pwd[8*i +: 8];
        end else if (prd) begin
          pd = (pa < DEPTH) ? mm[pa] : '0;
          ev[pg-1] = 1'b1; ed[pg-1] = pd;
          nv[pg-1] = 1'b1; nd[pg-1] = pd;
        end
      end
    end
    #1;
    ov[0] = a_rv1; ov[1] = a_rv2; ov[2] = b_rv1; ov[3] = b_rv2;
    od[0] = a_rd1; od[1] = a_rd2; od[2] = b_rd1; od[3] = b_rd2;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (ov[k] !== ev[k]) begin failures++; $display("FAIL rvalid[%0d] got=%b exp=%b t=%0t", k, ov[k], ev[k], $time); end
      checks++;
      if (od[k] !== ed[k]) begin failures++; $display("FAIL rdata[%0d] got=%h exp=%h t=%0t", k, od[k], ed[k], $time); end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic idle();
    s1_chipselect = 1'b0; s1_read = 1'b0; s1_write = 1'b0;
    s2_chipselect = 1'b0; s2_read = 1'b0; s2_write = 1'b0;
    clken = 1'b1; reset_req = 1'b0; freeze = 1'b0;
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic s1_rd(input int a);
    s1_chipselect = 1'b1; s1_read = 1'b1; s1_write = 1'b0; s1_address = AW'(a);
  endtask

  task automatic s2_rd(input int a);
    s2_chipselect = 1'b1; s2_read = 1'b1; s2_write = 1'b0; s2_address = AW'(a);
  endtask

  task automatic s1_wrt(input int a, input logic [DW-1:0] d, input logic [BW-1:0] be);
    s1_chipselect = 1'b1; s1_read = 1'b0; s1_write = 1'b1; s1_address = AW'(a);
    s1_writedata = d; s1_byteenable = be;
  endtask

  task automatic s2_wrt(input int a, input logic [DW-1:0] d, input logic [BW-1:0] be);
    s2_chipselect = 1'b1; s2_read = 1'b0; s2_write = 1'b1; s2_address = AW'(a);
    s2_writedata = d; s2_byteenable = be;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    idle(); rst = 1'b1; tick(); tick();
    checks++;
    if ({a_rd1, a_rd2, b_rd1, b_rd2} !== 128'd0) begin
      failures++; $display("FAIL reset_rdata got=%h exp=0", {a_rd1, a_rd2, b_rd1, b_rd2});
    end
    checks++;
    if ({a_rv1, a_rv2, b_rv1, b_rv2} !== 4'b0) begin
      failures++; $display("FAIL reset_rvalid got=%b exp=0000", {a_rv1, a_rv2, b_rv1, b_rv2});
    end
    rst = 1'b0; tick();
  endtask

  task automatic test_init();
    for (int a = 0; a < 32; a++) begin
      s1_wrt(a, $urandom, 4'hF); tick();
    end
    idle(); tick();
  endtask

  task automatic test_basic();
    s1_wrt(5, 32'hDEADBEEF, 4'hF); tick();
    s1_rd(5); tick();
    checks++;
    if (a_rv1 !== 1'b1 || a_rd1 !== 32'hDEADBEEF) begin
      failures++; $display("FAIL basic_l1 got=%b/%h exp=1/deadbeef", a_rv1, a_rd1);
    end
    checks++;
    if (a_rv2 !== 1'b0 || b_rv1 !== 1'b0) begin
      failures++; $display("FAIL basic_early got=%b%b exp=00", a_rv2, b_rv1);
    end
    idle(); tick();
    checks++;
    if (b_rv1 !== 1'b1 || b_rd1 !== 32'hDEADBEEF || a_rv1 !== 1'b0 || a_rd1 !== 32'hDEADBEEF) begin
      failures++; $display("FAIL basic_l2 got=%b/%h l1=%b/%h exp=1/deadbeef 0/deadbeef", b_rv1, b_rd1, a_rv1, a_rd1);
    end
  endtask

  task automatic test_byteenable();
    s1_wrt(7, 32'h11223344, 4'hF); tick();
    s1_wrt(7, 32'hAABBCCDD, 4'b0101); tick();
    s1_rd(7); tick();
    checks++;
    if (a_rv1 !== 1'b1 || a_rd1 !== 32'h11BB33DD) begin
      failures++; $display("FAIL byteen_merge got=%b/%h exp=1/11bb33dd", a_rv1, a_rd1);
    end
    s1_wrt(7, 32'hFFFFFFFF, 4'b0000); tick();
    s1_rd(7); tick();
    checks++;
    if (a_rd1 !== 32'h11BB33DD) begin
      failures++; $display("FAIL byteen_zero got=%h exp=11bb33dd", a_rd1);
    end
    s1_chipselect = 1'b1; s1_read = 1'b1; s1_write = 1'b1; s1_address = AW'(9);
    s1_writedata = 32'h5A5A0000; s1_byteenable = 4'hF; tick();
    checks++;
    if (a_rv1 !== 1'b0) begin failures++; $display("FAIL rdwr_novalid got=%b exp=0", a_rv1); end
    s1_rd(9); tick();
    checks++;
    if (a_rv1 !== 1'b1 || a_rd1 !== 32'h5A5A0000) begin
      failures++; $display("FAIL rdwr_as_write got=%b/%h exp=1/5a5a0000", a_rv1, a_rd1);
    end
    idle(); tick();
  endtask

  task automatic test_contention();
    int a1, a2, n1, n2, ga;
    idle(); rst = 1'b1; tick(); rst = 1'b0; tick();
    a1 = 10; a2 = 20; n1 = 0; n2 = 0;
    for (int i = 0; i < 4; i++) begin
      s1_rd(a1); s2_rd(a2);
      #1;
      checks++;
      if (a_wr1 !== (i % 2 == 1) || a_wr2 !== (i % 2 == 0)) begin
        failures++; $display("FAIL contention_wait[%0d] got=%b%b exp=%b%b", i, a_wr1, a_wr2, (i % 2 == 1), (i % 2 == 0));
      end
      ga = (i % 2 == 0) ? a1 : a2;
      tick();
      n1 += int'(a_rv1); n2 += int'(a_rv2);
      checks++;
      if (((i % 2 == 0) ? a_rd1 : a_rd2) !== mm[ga]) begin
        failures++; $display("FAIL contention_data[%0d] got=%h exp=%h", i, (i % 2 == 0) ? a_rd1 : a_rd2, mm[ga]);
      end
      if (i % 2 == 0) a1++; else a2++;
    end
    idle();
    checks++;
    if (n1 != 2 || n2 != 2) begin failures++; $display("FAIL contention_count got=%0d,%0d exp=2,2", n1, n2); end
    tick();
  endtask

  task automatic test_l2_pipeline();
    for (int i = 0; i < 5; i++) begin
      if (i < 4) s1_rd(i); else idle();
      tick();
      checks++;
      if (i == 0) begin
        if (b_rv1 !== 1'b0) begin failures++; $display("FAIL l2_pipe_early got=%b exp=0", b_rv1); end
      end else if (b_rv1 !== 1'b1 || b_rd1 !== mm[i-1] || b_rv2 !== 1'b0) begin
        failures++; $display("FAIL l2_pipe[%0d] got=%b/%h s2v=%b exp=1/%h s2v=0", i, b_rv1, b_rd1, b_rv2, mm[i-1]);
      end
    end
    tick();
    checks++;
    if (b_rv1 !== 1'b0) begin failures++; $display("FAIL l2_pipe_end got=%b exp=0", b_rv1); end
  endtask

  task automatic test_stall_range();
    logic [DW-1:0] v0;
    idle(); freeze = 1'b1; s2_rd(3);
    for (int j = 0; j < 5; j++) begin
      if (j == 3) begin freeze = 1'b0; clken = 1'b0; end
      if (j == 4) begin clken = 1'b1; reset_req = 1'b1; end
      #1;
      checks++;
      if (a_wr2 !== 1'b1 || b_wr2 !== 1'b1) begin failures++; $display("FAIL stall_wait[%0d] got=%b%b exp=11", j, a_wr2, b_wr2); end
      tick();
      checks++;
      if (a_rv2 !== 1'b0 || b_rv2 !== 1'b0) begin failures++; $display("FAIL stall_novalid[%0d] got=%b%b exp=00", j, a_rv2, b_rv2); end
    end
    reset_req = 1'b0;
    #1;
    checks++;
    if (a_wr2 !== 1'b0) begin failures++; $display("FAIL stall_release got=%b exp=0", a_wr2); end
    tick();
    checks++;
    if (a_rv2 !== 1'b1 || a_rd2 !== mm[3]) begin failures++; $display("FAIL stall_read got=%b/%h exp=1/%h", a_rv2, a_rd2, mm[3]); end
    s2_rd(DEPTH); tick();
    checks++;
    if (a_rv2 !== 1'b1 || a_rd2 !== 32'd0) begin failures++; $display("FAIL oor_read got=%b/%h exp=1/0", a_rv2, a_rd2); end
    v0 = mm[0];
    s2_wrt(DEPTH, 32'hFFFFFFFF, 4'hF); tick();
    s2_rd(0); tick();
    checks++;
    if (a_rv2 !== 1'b1 || a_rd2 !== v0) begin failures++; $display("FAIL oor_write got=%b/%h exp=1/%h", a_rv2, a_rd2, v0); end
    idle(); tick();
  endtask

  task automatic test_reset_mid_read();
    idle(); s1_rd(5); tick();
    rst = 1'b1; idle();
    #1;
    checks++;
    if (a_rv1 !== 1'b0 || b_rv1 !== 1'b0 || a_rd1 !== 32'd0) begin
      failures++; $display("FAIL midreset_clear got=%b%b/%h exp=00/0", a_rv1, b_rv1, a_rd1);
    end
    #1; rst = 1'b0;
    tick();
    checks++;
    if (b_rv1 !== 1'b0 || b_rd1 !== 32'd0) begin
      failures++; $display("FAIL midreset_l2 got=%b/%h exp=0/0", b_rv1, b_rd1);
    end
    s1_rd(5); s2_rd(6);
    #1;
    checks++;
    if (a_wr1 !== 1'b0 || a_wr2 !== 1'b1) begin failures++; $display("FAIL midreset_prio got=%b%b exp=01", a_wr1, a_wr2); end
    tick();
    checks++;
    if (a_rv1 !== 1'b1 || a_rd1 !== 32'hDEADBEEF) begin
      failures++; $display("FAIL midreset_keep got=%b/%h exp=1/deadbeef", a_rv1, a_rd1);
    end
    s1_chipselect = 1'b0;
    tick();
    checks++;
    if (a_rv2 !== 1'b1 || a_rd2 !== mm[6]) begin failures++; $display("FAIL midreset_s2 got=%b/%h exp=1/%h", a_rv2, a_rd2, mm[6]); end
    idle(); tick();
  endtask

  task automatic test_random();
    bit h1, h2;
    int r;
    h1 = 1'b0; h2 = 1'b0;
    for (int n = 0; n < 400; n++) begin
      if (!h1) begin
        r = int'($urandom_range(0, 2));
        s1_chipselect = ($urandom_range(0, 3) != 0);
        s1_read = (r != 1); s1_write = (r != 0);
        s1_address = ($urandom_range(0, 7) == 0) ? AW'(DEPTH + int'($urandom_range(0, 3))) : AW'($urandom_range(0, 31));
        s1_byteenable = BW'($urandom); s1_writedata = $urandom;
      end
      if (!h2) begin
        r = int'($urandom_range(0, 2));
        s2_chipselect = ($urandom_range(0, 3) != 0);
        s2_read = (r != 1); s2_write = (r != 0);
        s2_address = ($urandom_range(0, 7) == 0) ? AW'(DEPTH + int'($urandom_range(0, 3))) : AW'($urandom_range(0, 31));
        s2_byteenable = BW'($urandom); s2_writedata = $urandom;
      end
      clken = ($urandom_range(0, 7) != 0);
      reset_req = ($urandom_range(0, 15) == 0);
      freeze = ($urandom_range(0, 15) == 0);
      #1;
      h1 = a_wr1; h2 = a_wr2;
      tick();
    end
    idle(); tick(); tick(); tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

  initial begin
    tick();
    test_reset();
    test_init();
    test_basic();
    test_byteenable();
    test_contention();
    test_l2_pipeline();
    test_stall_range();
    test_reset_mid_read();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
